// File: rtl/frame_buffer_writer.sv
// Camera-side frame buffer writer: turns the pixel stream into linear raster
// BRAM writes and flips between two banks only after a complete frame.
module frame_buffer_writer #(
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240,
    parameter int ADDR_WIDTH   = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  frame_start_in,
    input  logic                  pixel_valid_in,
    input  logic [7:0]            pixel_in,
    output logic                  we_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [7:0]            data_out,
    output logic                  write_bank_out,
    output logic                  read_bank_out,
    output logic                  frame_done_out,
    output logic [8:0]            hcount_out,
    output logic [7:0]            vcount_out,
    output logic                  overflow_out
);

    localparam logic [8:0] HLast = 9'(FRAME_WIDTH - 1);
    localparam logic [7:0] VLast = 8'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StCapture, StCommit} state_e;

    state_e                state_q, state_d;
    // Position of the next pixel to be accepted.
    logic [8:0]            h_cnt_q, h_cnt_d;
    logic [7:0]            v_cnt_q, v_cnt_d;
    logic [ADDR_WIDTH-1:0] a_cnt_q, a_cnt_d;
    // Registered write port and status outputs.
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [8:0]            hout_q, hout_d;
    logic [7:0]            vout_q, vout_d;
    logic                  bank_q, bank_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    // A frame was committed and no new frame has been started since.
    logic                  full_q, full_d;

    logic [8:0]            cur_h;
    logic [7:0]            cur_v;
    logic [ADDR_WIDTH-1:0] cur_a;
    logic                  capturing;

    // Next-state: frame sequencing, pixel acceptance and running address.
    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        a_cnt_d   = a_cnt_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        hout_d    = hout_q;
        vout_d    = vout_q;
        bank_d    = bank_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        full_d    = full_q;
        cur_h     = h_cnt_q;
        cur_v     = v_cnt_q;
        cur_a     = a_cnt_q;
        capturing = (state_q == StCapture);

        unique case (state_q)
            StIdle, StCapture: begin
                // A frame start restarts the raster; a coincident pixel lands at 0.
                if (frame_start_in) begin
                    cur_h     = '0;
                    cur_v     = '0;
                    cur_a     = '0;
                    capturing = 1'b1;
                    full_d    = 1'b0;
                    state_d   = StCapture;
                end
                h_cnt_d = cur_h;
                v_cnt_d = cur_v;
                a_cnt_d = cur_a;
                if (pixel_valid_in) begin
                    if (capturing) begin
                        we_d    = 1'b1;
                        addr_d  = cur_a;
                        data_d  = pixel_in;
                        hout_d  = cur_h;
                        vout_d  = cur_v;
                        a_cnt_d = cur_a + 1'b1;
                        if (cur_h == HLast) begin
                            h_cnt_d = '0;
                            v_cnt_d = cur_v + 1'b1;
                        end else begin
                            h_cnt_d = cur_h + 1'b1;
                        end
                        if (cur_h == HLast && cur_v == VLast) begin
                            // Last pixel: its write and frame_done share the COMMIT cycle.
                            state_d = StCommit;
                            done_d  = 1'b1;
                            full_d  = 1'b1;
                        end
                    end else if (full_q) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            StCommit: begin
                bank_d  = ~bank_q;
                h_cnt_d = '0;
                v_cnt_d = '0;
                a_cnt_d = '0;
                if (pixel_valid_in) begin
                    ovf_d = 1'b1;
                end
                if (frame_start_in) begin
                    full_d  = 1'b0;
                    state_d = StCapture;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            a_cnt_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hout_q  <= '0;
            vout_q  <= '0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            a_cnt_q <= a_cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hout_q  <= hout_d;
            vout_q  <= vout_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            full_q  <= full_d;
        end
    end

    assign we_out         = we_q;
    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign write_bank_out = bank_q;
    assign read_bank_out  = ~bank_q;
    assign frame_done_out = done_q;
    assign hcount_out     = hout_q;
    assign vcount_out     = vout_q;
    assign overflow_out   = ovf_q;

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
Camera-side writer for the display frame buffer. It accepts the 8-bit camera pixel stream, generates linear raster write addresses, and issues one-cycle registered BRAM write strobes into a ping-pong (two-bank) buffer. The display read path consumes the bank this block is not writing. The bank swaps only after a complete frame, so the display never shows a torn frame.

Parameters:
FRAME_WIDTH, 320, active pixels per camera line
FRAME_HEIGHT, 240, active lines per camera frame
ADDR_WIDTH, 17, width of per-bank address; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous, active-high reset
frame_start_in  input  1  one-cycle pulse marking start of a camera frame
pixel_valid_in  input  1  qualifies pixel_in for one cycle
pixel_in  input  8  camera pixel data
we_out  output  1  BRAM write enable, one cycle per accepted pixel
addr_out  output  ADDR_WIDTH  BRAM write address within the active bank
data_out  output  8  BRAM write data
write_bank_out  output  1  bank currently being written
read_bank_out  output  1  bank the display should read; always ~write_bank_out
frame_done_out  output  1  one-cycle pulse when a complete frame is committed
hcount_out  output  9  column of the last accepted pixel
vcount_out  output  8  row of the last accepted pixel
overflow_out  output  1  sticky: pixel arrived beyond FRAME_WIDTH*FRAME_HEIGHT

Behaviour:
- Reset (rst_in high at a clock edge), next cycle:
  - we_out=0, addr_out=0, data_out=0, frame_done_out=0, overflow_out=0.
  - write_bank_out=0, read_bank_out=1.
  - hcount/vcount counters=0.
  - FSM=IDLE.
  - Reset overrides every other input on the same edge.
- FSM states: IDLE, CAPTURE, COMMIT.
- IDLE:
  - pixel_valid_in is ignored and we_out stays 0.
  - frame_start_in -> CAPTURE.
- CAPTURE:
  - Each pixel_valid_in with count < FRAME_WIDTH*FRAME_HEIGHT -> next cycle we_out=1, addr_out=vcount*FRAME_WIDTH+hcount, data_out=pixel_in. Latency is exactly 1 cycle.
  - Address is kept as a running counter (no multiplier). hcount increments. When hcount reaches FRAME_WIDTH-1, it wraps to 0 and vcount increments.
  - After the pixel at (FRAME_WIDTH-1, FRAME_HEIGHT-1) is accepted -> COMMIT.
- COMMIT, lasting one cycle:
  - write_bank_out toggles, read_bank_out follows.
  - frame_done_out=1 for exactly this cycle.
  - Counters and address clear to 0.
  - -> IDLE.
  - The last pixel's write (we_out=1) lands in the COMMIT cycle, still addressed to the old bank. The bank toggle is visible the cycle after.
- frame_start_in and pixel_valid_in in the same cycle, from IDLE or CAPTURE: that pixel is the first pixel of the new frame, at addr 0.
- frame_start_in mid-CAPTURE (short frame):
  - Counters restart at 0 and the FSM stays in CAPTURE.
  - No bank swap and no frame_done_out; the partial frame is overwritten.
- frame_start_in during COMMIT: the commit completes as specified, then the FSM enters CAPTURE directly instead of IDLE.
- pixel_valid_in in COMMIT: dropped, no write.
- we_out is low in every cycle that has no accepted pixel. Outside a write, addr_out and data_out hold their last values.
- Overflow: not reachable in normal flow because COMMIT ends capture. overflow_out sets if pixel_valid_in arrives in COMMIT or IDLE after a completed frame without an intervening frame_start_in. It clears only on reset.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset then idle pixels: pixel_valid_in pulses with no frame_start_in -> we_out stays 0, addr_out=0, write_bank_out=0.
- Full frame, 76800 valid pixels with pixel_in=addr[7:0] after frame_start_in:
  - Writes at addr 0..76799, one cycle after each input.
  - Last write addr=76799 with hcount_out=319, vcount_out=239.
  - frame_done_out pulses once and write_bank_out becomes 1.
- Line wrap: pixels 319 and 320 -> addr 319 then 320; hcount_out 319 -> 0; vcount_out 0 -> 1.
- Short frame: frame_start_in after 1000 pixels -> next pixel written at addr 0; no bank toggle and no frame_done_out.
- Gapped valid (1 cycle on, 3 off) plus same-cycle frame_start_in and pixel -> the coincident pixel is written at addr 0; addresses are contiguous with no writes in gaps.
- Reset asserted mid-frame at pixel 5000 -> all outputs at reset values next cycle; a new frame starts at addr 0 in bank 0.
